// File: rtl/rotor_stage.sv
// Enigma rotor stage: position/ring registers, stepping with notch carry, and
// registered forward/reverse substitution. Define ROTOR_DOUBLE_STEP_EN for middle-rotor double step.
module rotor_stage #(
    parameter int N = 26,
    parameter int W = 5,
    parameter logic [N*W-1:0] WIRING = {
        5'd8,  5'd11, 5'd3,  5'd19, 5'd14, 5'd1,  5'd22, 5'd7,  5'd0,
        5'd13, 5'd6,  5'd21, 5'd16, 5'd2,  5'd24, 5'd5,  5'd4,  5'd25,
        5'd18, 5'd15, 5'd10, 5'd9,  5'd23, 5'd12, 5'd20, 5'd17},
    parameter int NOTCH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         set,
    input  logic [W-1:0] pos_load,
    input  logic [W-1:0] ring_load,
    input  logic         key_stb,
    input  logic         step_in,
    input  logic         in_valid,
    input  logic         dir,
    input  logic [W-1:0] in_idx,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic         carry_out,
    output logic [W-1:0] pos,
    output logic         err
);
    localparam logic [W:0]   NW      = (W+1)'(N);
    localparam logic [W-1:0] NOTCH_W = W'(NOTCH);
    localparam logic [W-1:0] LAST_W  = W'(N - 1);

    logic [W-1:0] pos_q, pos_d;
    logic [W-1:0] ring_q, ring_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         out_valid_q, out_valid_d;
    logic         carry_q, carry_d;
    logic         err_q, err_d;

    logic         load_ok;
    logic         idx_ok;
    logic         step_fire;
    logic [W-1:0] off;
    logic [W-1:0] c_idx;
    logic [W-1:0] fwd_val;
    logic [W-1:0] rev_val;
    logic [W-1:0] sub_res;

    // Operands are both < N (or b == N), so one conditional subtract suffices.
    function automatic logic [W-1:0] add_mod(input logic [W:0] a, input logic [W:0] b);
        logic [W:0] s;
        s = a + b;
        return W'((s >= NW) ? s - NW : s);
    endfunction

`ifdef ROTOR_DOUBLE_STEP_EN
    assign step_fire = !set && (step_in || (key_stb && (pos_q == NOTCH_W)));
`else
    logic unused_key_stb;
    assign unused_key_stb = key_stb;
    assign step_fire      = !set && step_in;
`endif

    assign load_ok = ({1'b0, pos_load} < NW) && ({1'b0, ring_load} < NW);
    assign idx_ok  = {1'b0, in_idx} < NW;

    always_comb begin
        off     = add_mod({1'b0, pos_q}, NW - {1'b0, ring_q});
        c_idx   = add_mod({1'b0, in_idx}, {1'b0, off});
        fwd_val = '0;
        rev_val = '0;
        // Reverse lookup searches the wiring table, so INV never needs storing.
        for (int unsigned i = 0; i < N; i++) begin
            if (c_idx == W'(i))
                fwd_val = WIRING[i*W +: W];
            if (WIRING[i*W +: W] == c_idx)
                rev_val = W'(i);
        end
        sub_res = add_mod({1'b0, dir ? rev_val : fwd_val}, NW - {1'b0, off});
    end

    always_comb begin
        pos_d       = pos_q;
        ring_d      = ring_q;
        carry_d     = 1'b0;
        err_d       = 1'b0;
        out_valid_d = in_valid;
        out_idx_d   = out_idx_q;

        if (set) begin
            if (load_ok) begin
                pos_d  = pos_load;
                ring_d = ring_load;
            end else begin
                err_d = 1'b1;
            end
        end else if (step_fire) begin
            pos_d   = (pos_q == LAST_W) ? '0 : pos_q + 1'b1;
            carry_d = (pos_q == NOTCH_W);
        end

        if (in_valid) begin
            if (idx_ok) begin
                out_idx_d = sub_res;
            end else begin
                out_idx_d = '0;
                err_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_q       <= '0;
            ring_q      <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            ring_q      <= ring_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
        end
    end

    assign pos       = pos_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign carry_out = carry_q;
    assign err       = err_q;
endmodule

// File: tb/tb_rotor_stage.sv
// Self-checking bench for rotor_stage: arithmetic reference model plus literal spot checks.
module tb_rotor_stage;
    localparam int N     = 26;
    localparam int W     = 5;
    localparam int NOTCH = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         set;
    logic [W-1:0] pos_load;
    logic [W-1:0] ring_load;
    logic         key_stb;
    logic         step_in;
    logic         in_valid;
    logic         dir;
    logic [W-1:0] in_idx;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic         carry_out;
    logic [W-1:0] pos;
    logic         err;

    int checks   = 0;
    int failures = 0;

    int wiring[N] = '{17,20,12,23,9,10,15,18,25,4,5,24,2,16,21,6,13,0,7,22,1,14,19,3,11,8};
    int inv[N];

    // Model state: mirrors the architecturally visible registers.
    int m_pos, m_ring, e_valid, e_idx, e_carry, e_err;

    rotor_stage #(.N(N), .W(W), .NOTCH(NOTCH)) dut (
        .clock(clock), .reset(reset), .set(set), .pos_load(pos_load),
        .ring_load(ring_load), .key_stb(key_stb), .step_in(step_in),
        .in_valid(in_valid), .dir(dir), .in_idx(in_idx), .out_valid(out_valid),
        .out_idx(out_idx), .carry_out(carry_out), .pos(pos), .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int substitute(input int p, input int r, input int x, input bit rev);
        int off, c;
        off = (p - r + N) % N;
        c   = (x + off) % N;
        return ((rev ? inv[c] : wiring[c]) - off + N) % N;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_ring = 0; e_valid = 0; e_idx = 0; e_carry = 0; e_err = 0;
    endtask

    task automatic model_step();
        bit fire;
        int n_pos;
`ifdef ROTOR_DOUBLE_STEP_EN
        fire = !set && (step_in || (key_stb && m_pos == NOTCH));
`else
        fire = !set && step_in;
`endif
        n_pos   = m_pos;
        e_carry = 0;
        e_err   = 0;
        e_valid = int'(in_valid);
        if (in_valid) begin
            if (int'(in_idx) >= N) begin
                e_idx = 0;
                e_err = 1;
            end else begin
                e_idx = substitute(m_pos, m_ring, int'(in_idx), dir);
            end
        end
        if (set) begin
            if (int'(pos_load) < N && int'(ring_load) < N) begin
                n_pos  = int'(pos_load);
                m_ring = int'(ring_load);
            end else begin
                e_err = 1;
            end
        end else if (fire) begin
            n_pos   = (m_pos + 1) % N;
            e_carry = (m_pos == NOTCH) ? 1 : 0;
        end
        m_pos = n_pos;
    endtask

    // One clock: model advances on the current inputs, DUT sampled 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check("pos", int'(pos), m_pos);
        check("out_valid", int'(out_valid), e_valid);
        check("out_idx", int'(out_idx), e_idx);
        check("carry_out", int'(carry_out), e_carry);
        check("err", int'(err), e_err);
    endtask

    task automatic drive(input bit s, input int pl, input int rl, input bit ks,
                         input bit si, input bit iv, input bit d, input int ix);
        set = s; pos_load = W'(pl); ring_load = W'(rl); key_stb = ks;
        step_in = si; in_valid = iv; dir = d; in_idx = W'(ix);
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) inv[wiring[i]] = i;

        reset = 1'b1;
        set = 0; pos_load = '0; ring_load = '0; key_stb = 0; step_in = 0;
        in_valid = 0; dir = 0; in_idx = '0;
        model_reset();
        #2;
        check("rst_pos", int'(pos), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_idx", int'(out_idx), 0);
        check("rst_carry", int'(carry_out), 0);
        check("rst_err", int'(err), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic forward/reverse at pos=0 ring=0
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        check("lit_fwd0", int'(out_idx), 17);
        check("lit_fwd0_v", int'(out_valid), 1);
        drive(0, 0, 0, 0, 0, 1, 1, 17);
        check("lit_rev17", int'(out_idx), 0);

        // Offsets from position and ring
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        check("lit_pos1", int'(out_idx), 19);
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        check("lit_ring1", int'(out_idx), 17);
        idle();
        check("lit_hold_idx", int'(out_idx), 17);

        // Wrap and notch carry
        drive(1, 25, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        check("lit_wrap_pos", int'(pos), 0);
        check("lit_wrap_carry", int'(carry_out), 0);
        drive(1, 16, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        check("lit_notch_pos", int'(pos), 17);
        check("lit_notch_carry", int'(carry_out), 1);
        idle();
        check("lit_carry_drop", int'(carry_out), 0);

        // Load errors, set priority, bad index
        drive(1, 30, 0, 0, 0, 0, 0, 0);
        check("lit_badload_err", int'(err), 1);
        check("lit_badload_pos", int'(pos), 17);
        drive(1, 3, 26, 0, 0, 0, 0, 0);
        check("lit_badring_err", int'(err), 1);
        drive(1, 5, 0, 0, 1, 0, 0, 0);
        check("lit_setprio_pos", int'(pos), 5);
        check("lit_setprio_carry", int'(carry_out), 0);
        drive(0, 0, 0, 0, 0, 1, 0, 27);
        check("lit_badidx_idx", int'(out_idx), 0);
        check("lit_badidx_err", int'(err), 1);
        check("lit_badidx_v", int'(out_valid), 1);

        // Optional double step
        drive(1, 16, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
`ifdef ROTOR_DOUBLE_STEP_EN
        check("lit_dbl_pos", int'(pos), 17);
        check("lit_dbl_carry", int'(carry_out), 1);
`else
        check("lit_dbl_pos", int'(pos), 16);
        check("lit_dbl_carry", int'(carry_out), 0);
`endif
        drive(1, 16, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        check("lit_both_pos", int'(pos), 17);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 11) == 0,
                  $urandom_range(0, 31), $urandom_range(0, 28),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 27));
        end

        // Reset mid-stream with a result and carry pending
        drive(1, 16, 4, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 1, 9);
        check("lit_pre_rst_v", int'(out_valid), 1);
        check("lit_pre_rst_carry", int'(carry_out), 1);
        reset = 1'b1;
        #1;
        model_reset();
        check("lit_async_valid", int'(out_valid), 0);
        check("lit_async_carry", int'(carry_out), 0);
        check("lit_async_pos", int'(pos), 0);
        check("lit_async_idx", int'(out_idx), 0);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        check("lit_post_rst", int'(out_idx), 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rotor_stage.md
Name: rotor_stage

Overview:
- Clocked, parametrised rotor stage for the Enigma datapath.
- Holds rotor position and ring setting, and steps on request.
- Emits a carry (notch) pulse to drive the next rotor.
- Performs registered forward or reverse substitution on a binary letter index. It is chained right-to-left by the machine controller, with the reflector between the forward and reverse passes.

Parameters:
- N, 26: alphabet size; all indices are mod N.
- W, 5: index width; must satisfy 2^W >= N.
- WIRING, {17,20,12,23,9,10,15,18,25,4,5,24,2,16,21,6,13,0,7,22,1,14,19,3,11,8}: flat N*W-bit vector. Entry i sits at bits [i*W +: W] and is the forward output contact for input contact i.
- NOTCH, 16: position at which a step produces carry_out.

Ports:
- clock, input, 1: single clock; rising edge.
- reset, input, 1: asynchronous, active-high reset.
- set, input, 1: load strobe for pos_load and ring_load.
- pos_load, input, W: start position.
- ring_load, input, W: ring setting.
- key_stb, input, 1: one-cycle pulse per keypress (used by the optional feature).
- step_in, input, 1: one-cycle step request (carry from the right rotor, or the controller for the rightmost rotor).
- in_valid, input, 1: substitution request.
- dir, input, 1: 0 = forward (right-to-left), 1 = reverse.
- in_idx, input, W: input letter index.
- out_valid, output, 1: result valid.
- out_idx, output, W: substituted letter index.
- carry_out, output, 1: step pulse for the next rotor.
- pos, output, W: current position.
- err, output, 1: one-cycle error pulse.

Behaviour:
- Reset (async):
  - pos = 0, ring = 0.
  - out_valid = 0, out_idx = 0, carry_out = 0, err = 0.
  - Reset may assert at any time. Any in-flight result is discarded.
- Load:
  - set=1 and both pos_load < N and ring_load < N: pos and ring are loaded next edge.
  - Either value >= N: registers unchanged; err=1 for one cycle.
  - set has priority over stepping. A step in the same cycle is dropped and carry_out=0.
- Step:
  - A step fires when step_in=1 and set=0.
  - pos <= (pos+1) mod N; wraps N-1 -> 0.
  - If pos==NOTCH at the firing edge, carry_out=1 on the following cycle only. Otherwise carry_out=0.
  - carry_out is a registered one-cycle pulse and is never held high.
- Substitution (latency 1 cycle):
  - Uses pos and ring as registered before this edge. The controller must step first, then issue the substitution on a later cycle.
  - off = (pos - ring) mod N.
  - Forward:
    - c = (in_idx + off) mod N
    - out_idx = (WIRING[c] - off + N) mod N
  - Reverse:
    - c = (in_idx + off) mod N
    - out_idx = (INV[c] - off + N) mod N
    - INV is the inverse permutation of WIRING, derived combinationally/elaborated in RTL.
  - All mod-N arithmetic uses W+1-bit intermediates with conditional subtract of N. There is no % operator.
  - in_valid=1 with in_idx >= N: out_valid=1, out_idx=0, err=1, all in the same cycle as the result.
  - out_valid=0 when no request. out_idx holds its last value.
- Simultaneous events:
  - A substitution and a step in the same cycle are both performed.
  - The result uses the old pos; pos updates for the next cycle.
  - Back-to-back substitutions are accepted every cycle. No backpressure.

Optional Feature:
- Macro: ROTOR_DOUBLE_STEP_EN.
- Defined: a step also fires when key_stb=1, set=0 and pos==NOTCH, even if step_in=0. This is the middle-rotor double step.
  - The rotor advances once, and carry_out pulses next cycle.
  - step_in and key_stb together still give exactly one advance.
- Not defined: key_stb is ignored; stepping comes only from step_in.

Test Plan:
1. Reset, set pos_load=0, ring_load=0; forward in_idx=0 -> out_idx=17 one cycle later, out_valid=1; reverse in_idx=17 -> out_idx=0.
2. pos=1, ring=0: forward in_idx=0 -> c=1, WIRING=20, out_idx=19. Same with ring=1 (off=0) -> out_idx=17.
3. pos=25, pulse step_in -> pos=0 next cycle, carry_out=0. pos=16, step_in -> pos=17, carry_out=1 for exactly one cycle.
4. set with pos_load=30 -> err pulse, pos unchanged. set=1 and step_in=1 same cycle with pos_load=5 -> pos=5, carry_out=0. Forward in_idx=27 -> out_idx=0, err=1.
5. Assert reset mid-stream while out_valid=1 -> out_valid, carry_out, pos all 0 immediately (before next edge).
6. With ROTOR_DOUBLE_STEP_EN, pos=16, key_stb=1, step_in=0 -> pos=17, carry_out=1. Without the macro, the same stimulus -> pos stays 16, carry_out=0.
